// File: rtl/adder_32bit_seq.sv
// Serial 32-bit adder: processes CHUNK_W bits per cycle through an IDLE/ADD/DONE
// sequencer, then reports sum, unsigned carry-out and signed overflow with a done pulse.
module adder_32bit_seq #(
  parameter int unsigned CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [32:1] a,
  input  logic [32:1] b,
  output logic [32:1] y,
  output logic        cout,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned SHIFT_W    = 6;
  localparam int unsigned SUM_W      = CHUNK_W + 1;

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [DATA_W:1]   CHUNK_MASK = DATA_W'((33'(1) << CHUNK_W) - 33'(1));

  // Reject chunk widths that do not evenly tile the 32-bit word.
  if (!(CHUNK_W == 1 || CHUNK_W == 2 || CHUNK_W == 4 ||
        CHUNK_W == 8 || CHUNK_W == 16 || CHUNK_W == 32)) begin : g_bad_chunk_w
    $error("adder_32bit_seq: CHUNK_W must be one of 1, 2, 4, 8, 16, 32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W:1]  opa_q;
  logic [DATA_W:1]  opb_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [DATA_W:1]  opa_d;
  logic [DATA_W:1]  opb_d;
  logic             carry_d;
  logic [IDX_W-1:0] idx_d;
  logic [DATA_W:1]  y_d;
  logic             cout_d;
  logic             ovf_d;
  logic             busy_d;
  logic             done_d;

  logic [SHIFT_W-1:0] shift_c;
  logic [CHUNK_W-1:0] a_chunk_c;
  logic [CHUNK_W-1:0] b_chunk_c;
  logic [SUM_W-1:0]   sum_c;
  logic [DATA_W:1]    y_merge_c;
  logic               last_c;
  logic               accept_c;

  // Chunk slice and partial sum for the current index.
  always_comb begin
    shift_c   = SHIFT_W'(idx_q) * SHIFT_W'(CHUNK_W);
    a_chunk_c = CHUNK_W'(opa_q >> shift_c);
    b_chunk_c = CHUNK_W'(opb_q >> shift_c);
    sum_c     = SUM_W'(a_chunk_c) + SUM_W'(b_chunk_c) + SUM_W'(carry_q);
    y_merge_c = (y & ~(CHUNK_MASK << shift_c)) |
                (DATA_W'(sum_c[CHUNK_W-1:0]) << shift_c);
    last_c    = (idx_q == LAST_IDX);
    accept_c  = start && (state_q != ADD);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_c) state_d = DONE;
      DONE:    state_d = start ? ADD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    y_d     = y;
    cout_d  = cout;
    ovf_d   = ovf;
    busy_d  = (state_d == ADD);
    done_d  = (state_d == DONE);

    if (accept_c) begin
      opa_d   = a;
      opb_d   = b;
      carry_d = 1'b0;
      idx_d   = '0;
      y_d     = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == ADD) begin
      y_d     = y_merge_c;
      carry_d = sum_c[CHUNK_W];
      idx_d   = idx_q + IDX_W'(1);
      if (last_c) begin
        // Overflow uses the final sum MSB being written this cycle.
        cout_d = sum_c[CHUNK_W];
        ovf_d  = (opa_q[DATA_W] == opb_q[DATA_W]) && (y_merge_c[DATA_W] != opa_q[DATA_W]);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      y       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      y       <= y_d;
      cout    <= cout_d;
      ovf     <= ovf_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule
